// File: rtl/bullet_painter.sv
// Single-bullet object engine: owns position, motion and lifetime,
// and streams one draw/erase pixel per clock to the paint selector.
module bullet_painter #(
    parameter int          BULLET_W     = 4,
    parameter int          BULLET_H     = 2,
    parameter logic [2:0]  BULLET_COLOR = 3'b110,
    parameter logic [2:0]  BG_COLOR     = 3'b000,
    parameter int          SPEED        = 2,
    parameter int          STEP_TICKS   = 833333,
    parameter int          X_MAX        = 319,
    parameter int          TICK_W       = 20
) (
    input  logic       CLOCK_50,
    input  logic       rst,
    input  logic       fire,
    input  logic [8:0] start_x,
    input  logic [7:0] start_y,
    input  logic       dir,
    input  logic       hit,
    output logic       active,
    output logic [8:0] bullet_x,
    output logic [7:0] bullet_y,
    output logic [8:0] VGA_X,
    output logic [7:0] VGA_Y,
    output logic [2:0] VGA_color,
    output logic       plot_enable
);

    localparam int PXW = (BULLET_W > 1) ? $clog2(BULLET_W) : 1;
    localparam int PYW = (BULLET_H > 1) ? $clog2(BULLET_H) : 1;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] DRAW  = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] ERASE = 3'd3;
    localparam logic [2:0] MOVE  = 3'd4;

    logic [2:0]        state;
    logic              kill;
    logic              mv_dir;
    logic [PXW-1:0]    px;
    logic [PYW-1:0]    py;
    logic [TICK_W-1:0] tick;

    logic              s1_v;
    logic [8:0]        s1_x;
    logic [7:0]        s1_y;
    logic [2:0]        s1_c;

    logic              scan;
    logic              last_px;
    logic              last_py;
    logic              last_pix;
    logic              tick_done;
    logic [9:0]        x_ext;
    logic [9:0]        x_fwd;
    logic [9:0]        x_back;
    logic              off_edge;

    always_comb begin
        scan      = (state == DRAW) || (state == ERASE);
        last_px   = (px == PXW'(BULLET_W - 1));
        last_py   = (py == PYW'(BULLET_H - 1));
        last_pix  = last_px && last_py;
        tick_done = (tick == TICK_W'(STEP_TICKS - 1));
        x_ext     = {1'b0, bullet_x};
        x_fwd     = x_ext + 10'(SPEED);
        x_back    = x_ext - 10'(SPEED);
        // Checked in 10 bits so neither direction can wrap on screen.
        if (mv_dir)
            off_edge = x_ext < 10'(SPEED);
        else
            off_edge = (x_fwd + 10'(BULLET_W - 1)) > 10'(X_MAX);
    end

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            active   <= 1'b0;
            kill     <= 1'b0;
            mv_dir   <= 1'b0;
            px       <= '0;
            py       <= '0;
            tick     <= '0;
            bullet_x <= '0;
            bullet_y <= '0;
        end else begin
            if (scan) begin
                if (last_px) begin
                    px <= '0;
                    py <= last_py ? '0 : py + PYW'(1);
                end else begin
                    px <= px + PXW'(1);
                end
            end
            unique case (state)
                IDLE: begin
                    if (fire) begin
                        bullet_x <= start_x;
                        bullet_y <= start_y;
                        mv_dir   <= dir;
                        active   <= 1'b1;
                        px       <= '0;
                        py       <= '0;
                        state    <= DRAW;
                    end
                end
                DRAW: begin
                    if (hit)
                        kill <= 1'b1;
                    if (last_pix) begin
                        tick  <= '0;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    tick <= tick + TICK_W'(1);
                    if (hit)
                        kill <= 1'b1;
                    if (hit || tick_done)
                        state <= ERASE;
                end
                ERASE: begin
                    if (hit)
                        kill <= 1'b1;
                    if (last_pix) begin
                        if (kill || hit) begin
                            kill   <= 1'b0;
                            active <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            state <= MOVE;
                        end
                    end
                end
                MOVE: begin
                    if (hit)
                        kill <= 1'b1;
                    if (off_edge) begin
                        kill   <= 1'b0;
                        active <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        bullet_x <= mv_dir ? x_back[8:0] : x_fwd[8:0];
                        state    <= DRAW;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Two-stage pixel pipe: stage 1 forms the coordinate, stage 2 drives.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            s1_v        <= 1'b0;
            s1_x        <= '0;
            s1_y        <= '0;
            s1_c        <= '0;
            plot_enable <= 1'b0;
            VGA_X       <= '0;
            VGA_Y       <= '0;
            VGA_color   <= '0;
        end else begin
            s1_v <= scan;
            if (scan) begin
                s1_x <= bullet_x + 9'(px);
                s1_y <= bullet_y + 8'(py);
                s1_c <= (state == DRAW) ? BULLET_COLOR : BG_COLOR;
            end
            plot_enable <= s1_v;
            if (s1_v) begin
                VGA_X     <= s1_x;
                VGA_Y     <= s1_y;
                VGA_color <= s1_c;
            end
        end
    end

endmodule
